csi_crc16_check_ctrl: RTL and testbench
=======================================

Name: csi_crc16_check_ctrl

Overview:
- Sequences a bit-serial CSI-2 CRC-16 engine over one long-packet payload and compares the result with the 2-byte received checksum.
- Sits between the CSI-2 packet header decoder and the payload sink; it consumes the payload byte stream, then the CRC bytes.
- Reports pass/fail per packet and keeps an error count.

Parameters:
- WC_W, 16, width of the word-count (payload byte count) input.
- ERR_CNT_W, 16, width of the saturating CRC error counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- sop_i  in  1  start-of-packet strobe from the header decoder; sampled only in IDLE
- wc_i  in  WC_W  payload byte count; captured with sop_i
- data_i  in  8  stream byte: payload bytes first, then CRC LSB, then CRC MSB
- valid_i  in  1  data_i valid
- ready_o  out  1  byte accepted when valid_i && ready_o
- flush_i  in  1  abort current packet and return to IDLE
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the compare result is valid
- crc_ok_o  out  1  one-cycle pulse with done_o, received == computed
- crc_err_o  out  1  one-cycle pulse with done_o, received != computed
- crc_o  out  16  last computed CRC; held until the next sop_i
- err_cnt_o  out  ERR_CNT_W  saturating count of crc_err_o pulses

Behaviour:
- Reset (sync): state IDLE; ready_o, busy_o, done_o, crc_ok_o, crc_err_o all 0; crc_o 16'hFFFF; err_cnt_o 0.
- CRC definition:
  - polynomial x^16+x^12+x^5+1, reflected form 16'h8408, seed 16'hFFFF, LSB-first input, no final XOR.
  - per-bit step: fb = crc[0]^bit; crc = (crc>>1) ^ (fb ? 16'h8408 : 0).
- States: IDLE, LOAD, SHIFT, CRC_LO, CRC_HI, RESULT.
- IDLE:
  - ready_o = 0.
  - On sop_i: seed the engine with 16'hFFFF and latch wc_i into a remaining-byte counter.
  - Go to LOAD if wc_i != 0, else go to CRC_LO.
- LOAD:
  - ready_o = 1.
  - On handshake: latch the byte, bit index = 0, go to SHIFT.
- SHIFT:
  - ready_o = 0.
  - Feed bit[idx] to the engine each cycle for exactly 8 cycles.
  - On the 8th cycle, decrement the remaining count; go to LOAD if the count is nonzero, else CRC_LO.
  - Throughput is 1 byte per 9 cycles (handshake cycle plus 8 shift cycles) when valid_i is held high.
- CRC_LO: ready_o = 1; on handshake capture the received LSB, go to CRC_HI.
- CRC_HI:
  - ready_o = 1.
  - On handshake: capture the MSB, copy the engine value to crc_o, go to RESULT.
- RESULT:
  - One cycle only; done_o = 1 plus exactly one of crc_ok_o / crc_err_o.
  - err_cnt_o increments on error and saturates at all-ones.
  - Go to IDLE.
- valid_i low in LOAD/CRC_LO/CRC_HI: the block stalls with no timeout.
- flush_i: highest priority below reset.
  - In any state, the next state is IDLE and no done_o is issued.
  - crc_o and err_cnt_o are unchanged.
  - A flush during RESULT suppresses the done_o pulse.
- sop_i outside IDLE is ignored.
- A sop_i in the RESULT cycle is ignored; the decoder must wait for busy_o = 0.
- wc = 0: computed CRC is 16'hFFFF, checked against the received bytes.
- wc = max (2^WC_W − 1): the counter must not wrap; exactly 2^WC_W − 1 bytes are processed.

Optional Feature:
- Macro CSI_CRC_BYTEWIDE_EN.
- Defined:
  - The engine applies 8 unrolled bit steps in one cycle, so SHIFT is removed.
  - LOAD keeps ready_o = 1 continuously, giving 1 payload byte per cycle.
  - CRC results are identical to the serial build.
- Undefined: the bit-serial SHIFT sequencing above, using the 1-bit engine.

Decomposition:
- Package csi_crc_pkg holds:
  - CRC16_POLY_REFL = 16'h8408 and CRC16_SEED = 16'hFFFF;
  - the state enum type crc_chk_state_e;
  - a function crc16_step_bit(crc, bit).
- One sub-module, csi_crc16_engine, with ports clk_i, reset_i, seed_load_i, en_i, bit_i, byte_i, crc_o.
  - It is the bit-serial or byte-wide register selected by the macro.
  - Seed load is synchronous.
- The controller holds the FSM, counters, compare logic and error counter.

Test Plan:
- Payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 (wc=24), then CRC bytes F0 00 -> crc_o=16'h00F0, crc_ok_o pulse, err_cnt_o=0.
- Payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 (wc=24), then CRC bytes 69 E6 -> computed 16'hE569, crc_err_o pulse, err_cnt_o=1.
- wc=0, then CRC bytes FF FF -> crc_ok_o, crc_o=16'hFFFF; repeat with bytes 00 00 -> crc_err_o.
- Random valid_i gaps during the first vector -> same 16'h00F0 result; serial build shows ready_o high only in LOAD/CRC states, 9 cycles per byte at full valid.
- flush_i asserted after 10 bytes, then a fresh sop_i with the first vector -> no done_o for the aborted packet, second packet crc_ok_o.
- ERR_CNT_W=2 with 5 bad packets -> err_cnt_o saturates at 3; sync reset mid-SHIFT -> next cycle IDLE, ready_o=0, err_cnt_o=0.

Source files
------------

// File: rtl/csi_crc_pkg.sv
// Shared CRC-16 (reflected 0x8408, seed 0xFFFF) constants, FSM state type and step functions
// for the CSI-2 payload checksum controller.
package csi_crc_pkg;

    localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
    localparam logic [15:0] CRC16_SEED      = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_RESULT
    } crc_chk_state_e;

    function automatic logic [15:0] crc16_step_bit(input logic [15:0] crc, input logic bit_in);
        return (crc >> 1) ^ ((crc[0] ^ bit_in) ? CRC16_POLY_REFL : 16'h0000);
    endfunction

    // Eight LSB-first bit steps; identical result to feeding the byte serially.
    function automatic logic [15:0] crc16_step_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            c = crc16_step_bit(c, b[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi_crc16_check_ctrl_engine.sv
// CRC-16 register: bit-serial by default, one byte per cycle when CSI_CRC_BYTEWIDE_EN is defined.
module csi_crc16_engine
    import csi_crc_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        seed_load_i,
    input  logic        en_i,
    input  logic        bit_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;
    logic        unused_in;

`ifdef CSI_CRC_BYTEWIDE_EN
    assign unused_in = bit_i;
`else
    assign unused_in = ^byte_i;
`endif

    always_comb begin
        crc_d = crc_q;
        if (seed_load_i) begin
            crc_d = CRC16_SEED;
        end else if (en_i) begin
`ifdef CSI_CRC_BYTEWIDE_EN
            crc_d = crc16_step_byte(crc_q, byte_i);
`else
            crc_d = crc16_step_bit(crc_q, bit_i);
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            crc_q <= CRC16_SEED;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/csi_crc16_check_ctrl.sv
// CSI-2 long-packet CRC-16 check controller; build option CSI_CRC_BYTEWIDE_EN selects
// the one-byte-per-cycle engine instead of the 8-cycle bit-serial SHIFT sequencing.
module csi_crc16_check_ctrl
    import csi_crc_pkg::*;
#(
    parameter int unsigned WC_W      = 16,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 sop_i,
    input  logic [WC_W-1:0]      wc_i,
    input  logic [7:0]           data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 crc_ok_o,
    output logic                 crc_err_o,
    output logic [15:0]          crc_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    crc_chk_state_e       state_q, state_d;
    logic [WC_W-1:0]      cnt_q, cnt_d;
    logic [7:0]           rx_lo_q, rx_lo_d;
    logic [7:0]           rx_hi_q, rx_hi_d;
    logic [15:0]          crc_q, crc_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 hs;
    logic                 match;
    logic                 seed_load;
    logic                 eng_en;
    logic                 eng_bit;
    logic [15:0]          eng_crc;

`ifndef CSI_CRC_BYTEWIDE_EN
    logic [7:0] byte_q, byte_d;
    logic [2:0] idx_q, idx_d;
    assign eng_bit = byte_q[idx_q];
`else
    assign eng_bit = 1'b0;
`endif

    assign ready_o = (state_q == ST_LOAD) || (state_q == ST_CRC_LO) || (state_q == ST_CRC_HI);
    assign hs      = valid_i && ready_o;
    assign busy_o  = (state_q != ST_IDLE);
    assign match   = ({rx_hi_q, rx_lo_q} == crc_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_lo_d   = rx_lo_q;
        rx_hi_d   = rx_hi_q;
        crc_d     = crc_q;
        err_d     = err_q;
        seed_load = 1'b0;
        eng_en    = 1'b0;
        done_o    = 1'b0;
        crc_ok_o  = 1'b0;
        crc_err_o = 1'b0;
`ifndef CSI_CRC_BYTEWIDE_EN
        byte_d    = byte_q;
        idx_d     = idx_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (sop_i) begin
                    seed_load = 1'b1;
                    cnt_d     = wc_i;
                    state_d   = (wc_i != '0) ? ST_LOAD : ST_CRC_LO;
                end
            end
            ST_LOAD: begin
                if (hs) begin
`ifdef CSI_CRC_BYTEWIDE_EN
                    eng_en  = 1'b1;
                    cnt_d   = cnt_q - WC_W'(1);
                    state_d = (cnt_q == WC_W'(1)) ? ST_CRC_LO : ST_LOAD;
`else
                    byte_d  = data_i;
                    idx_d   = 3'd0;
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
`ifndef CSI_CRC_BYTEWIDE_EN
                eng_en = 1'b1;
                idx_d  = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    cnt_d   = cnt_q - WC_W'(1);
                    state_d = (cnt_q == WC_W'(1)) ? ST_CRC_LO : ST_LOAD;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_CRC_LO: begin
                if (hs) begin
                    rx_lo_d = data_i;
                    state_d = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                if (hs) begin
                    rx_hi_d = data_i;
                    crc_d   = eng_crc;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                done_o    = 1'b1;
                crc_ok_o  = match;
                crc_err_o = !match;
                if (!match && (err_q != '1)) begin
                    err_d = err_q + ERR_CNT_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush overrides every state action, including the RESULT pulse and counter update.
        if (flush_i) begin
            state_d   = ST_IDLE;
            crc_d     = crc_q;
            err_d     = err_q;
            seed_load = 1'b0;
            eng_en    = 1'b0;
            done_o    = 1'b0;
            crc_ok_o  = 1'b0;
            crc_err_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rx_lo_q <= '0;
            rx_hi_q <= '0;
            crc_q   <= CRC16_SEED;
            err_q   <= '0;
`ifndef CSI_CRC_BYTEWIDE_EN
            byte_q  <= '0;
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_lo_q <= rx_lo_d;
            rx_hi_q <= rx_hi_d;
            crc_q   <= crc_d;
            err_q   <= err_d;
`ifndef CSI_CRC_BYTEWIDE_EN
            byte_q  <= byte_d;
            idx_q   <= idx_d;
`endif
        end
    end

    csi_crc16_engine u_engine (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .seed_load_i (seed_load),
        .en_i        (eng_en),
        .bit_i       (eng_bit),
        .byte_i      (data_i),
        .crc_o       (eng_crc)
    );

    assign crc_o     = crc_q;
    assign err_cnt_o = err_q;

endmodule

// File: tb/tb_csi_crc16_check_ctrl.sv
// Directed bench for csi_crc16_check_ctrl using CSI-2 reference payload vectors.
module tb_csi_crc16_check_ctrl;

    logic        clk = 1'b0;
    logic        reset_i, sop_i, valid_i, flush_i;
    logic [15:0] wc_i;
    logic [7:0]  data_i;
    logic        ready_o, busy_o, done_o, crc_ok_o, crc_err_o;
    logic [15:0] crc_o, err_cnt_o;
    logic        ready2, busy2, done2, ok2, err2;
    logic [15:0] crc2;
    logic [1:0]  err_cnt2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned done_cnt = 0;
    time         hs_last = 0, hs_prev = 0;

    logic [7:0] v1 [24];
    logic [7:0] v2 [24];

`ifdef CSI_CRC_BYTEWIDE_EN
    localparam time BYTE_PERIOD = 10;
    localparam logic READY_AFTER_BYTE = 1'b1;
`else
    localparam time BYTE_PERIOD = 90;
    localparam logic READY_AFTER_BYTE = 1'b0;
`endif

    always #5 clk = ~clk;

    csi_crc16_check_ctrl dut (
        .clk_i(clk), .reset_i(reset_i), .sop_i(sop_i), .wc_i(wc_i), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i), .busy_o(busy_o),
        .done_o(done_o), .crc_ok_o(crc_ok_o), .crc_err_o(crc_err_o), .crc_o(crc_o),
        .err_cnt_o(err_cnt_o)
    );

    csi_crc16_check_ctrl #(.WC_W(16), .ERR_CNT_W(2)) dut2 (
        .clk_i(clk), .reset_i(reset_i), .sop_i(sop_i), .wc_i(wc_i), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready2), .flush_i(flush_i), .busy_o(busy2),
        .done_o(done2), .crc_ok_o(ok2), .crc_err_o(err2), .crc_o(crc2),
        .err_cnt_o(err_cnt2)
    );

    always @(negedge clk) if (done_o) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input logic [15:0] w);
        sop_i = 1'b1;
        wc_i  = w;
        @(negedge clk);
        sop_i = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int unsigned t = 0;
        if (gaps) begin
            valid_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        data_i  = b;
        valid_i = 1'b1;
        while (!ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $error("FAIL handshake_timeout: observed ready_o=0 expected ready_o=1 within 200 cycles");
        end
        hs_prev = hs_last;
        hs_last = $time;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic run_pkt(input string tag, input logic [15:0] w, input logic [7:0] p [24],
                           input logic [7:0] lo, input logic [7:0] hi, input bit gaps,
                           input logic [15:0] exp_crc, input logic exp_ok);
        start_pkt(w);
        for (int i = 0; i < int'(w); i++) begin
            send_byte(p[i], gaps);
        end
        send_byte(lo, gaps);
        send_byte(hi, gaps);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_ok"}, {31'd0, crc_ok_o}, {31'd0, exp_ok});
        chk({tag, "_err"}, {31'd0, crc_err_o}, {31'd0, !exp_ok});
        chk({tag, "_crc"}, {16'd0, crc_o}, {16'd0, exp_crc});
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done_clr"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        int unsigned d0;
        v1 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
               8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        v2 = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7, 8'h4F, 8'h82, 8'h78, 8'hC5,
               8'h82, 8'hE0, 8'h8C, 8'h70, 8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};
        reset_i = 1'b1; sop_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0; wc_i = '0; data_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {29'd0, done_o, crc_ok_o, crc_err_o}, 32'd0);
        chk("rst_crc", {16'd0, crc_o}, 32'h0000FFFF);
        chk("rst_errcnt", {16'd0, err_cnt_o}, 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Vector 1 at full rate, with ready/throughput checks on the first two bytes.
        start_pkt(16'd24);
        chk("load_ready", {31'd0, ready_o}, 32'd1);
        chk("load_busy", {31'd0, busy_o}, 32'd1);
        send_byte(v1[0], 1'b0);
        chk("after_byte_ready", {31'd0, ready_o}, {31'd0, READY_AFTER_BYTE});
        send_byte(v1[1], 1'b0);
        chk("byte_period", 32'(hs_last - hs_prev), 32'(BYTE_PERIOD));
        for (int i = 2; i < 24; i++) send_byte(v1[i], 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("v1_done", {31'd0, done_o}, 32'd1);
        chk("v1_ok", {31'd0, crc_ok_o}, 32'd1);
        chk("v1_crc", {16'd0, crc_o}, 32'h000000F0);
        @(negedge clk);
        chk("v1_errcnt", {16'd0, err_cnt_o}, 32'd0);

        run_pkt("v2", 16'd24, v2, 8'h69, 8'hE6, 1'b0, 16'hE569, 1'b0);
        chk("v2_errcnt", {16'd0, err_cnt_o}, 32'd1);

        run_pkt("wc0_ok", 16'd0, v1, 8'hFF, 8'hFF, 1'b0, 16'hFFFF, 1'b1);
        run_pkt("wc0_bad", 16'd0, v1, 8'h00, 8'h00, 1'b0, 16'hFFFF, 1'b0);
        chk("wc0_errcnt", {16'd0, err_cnt_o}, 32'd2);

        run_pkt("v1_gaps", 16'd24, v1, 8'hF0, 8'h00, 1'b1, 16'h00F0, 1'b1);

        // Flush after 10 payload bytes: no done, crc/err count untouched.
        d0 = done_cnt;
        start_pkt(16'd24);
        for (int i = 0; i < 10; i++) send_byte(v1[i], 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_idle", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        chk("flush_no_done", done_cnt, d0);
        chk("flush_crc", {16'd0, crc_o}, 32'h000000F0);
        chk("flush_errcnt", {16'd0, err_cnt_o}, 32'd2);
        run_pkt("v1_after_flush", 16'd24, v1, 8'hF0, 8'h00, 1'b0, 16'h00F0, 1'b1);

        for (int k = 0; k < 5; k++) begin
            run_pkt("bad", 16'd0, v1, 8'h12, 8'h34, 1'b0, 16'hFFFF, 1'b0);
        end
        chk("errcnt16_after_bad", {16'd0, err_cnt_o}, 32'd7);
        chk("errcnt2_saturated", {30'd0, err_cnt2}, 32'd3);

        // Synchronous reset while shifting the first payload byte.
        start_pkt(16'd24);
        send_byte(v1[0], 1'b0);
        reset_i = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_ready", {31'd0, ready_o}, 32'd0);
        chk("midrst_errcnt", {16'd0, err_cnt_o}, 32'd0);
        chk("midrst_errcnt2", {30'd0, err_cnt2}, 32'd0);
        chk("midrst_crc", {16'd0, crc_o}, 32'h0000FFFF);
        reset_i = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
